apb_slave_fsm: RTL

APB_SLAVE_FSM -- requirements
Module: apb_slave_fsm

---
 rtl/apb_slave_fsm_pkg.sv | 20 ++
 rtl/apb_prot_check.sv | 31 +++
 rtl/apb_slave_fsm.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/apb_slave_fsm_pkg.sv
// Shared APB slave definitions: FSM state encoding, PPROT bit positions and
// the default address-map boundaries for the secure and privileged regions.
// Ports: none (package).
package apb_slave_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int PROT_PRIV  = 0;
  localparam int PROT_NSEC  = 1;
  localparam int PROT_INSTR = 2;

  localparam logic [7:0] SEC_BASE_DEFAULT = 8'hC0;
  localparam logic [7:0] PRIV_TOP_DEFAULT = 8'h0F;

endpackage

// File: rtl/apb_prot_check.sv
// APB access permission check, purely combinational.
// Ports: prot (PPROT bits), addr (byte address), write (1=write) -> deny (1=reject).
// Rejects instruction fetches, non-secure accesses at or above SEC_BASE and
// unprivileged writes at or below PRIV_TOP.
module apb_prot_check
  import apb_slave_fsm_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SEC_BASE = SEC_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] PRIV_TOP = PRIV_TOP_DEFAULT
) (
  input  logic [2:0]        prot,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic              deny
);

  always_comb begin
    deny = 1'b0;
    if (prot[PROT_INSTR]) begin
      deny = 1'b1;
    end
    if (prot[PROT_NSEC] && (addr >= SEC_BASE)) begin
      deny = 1'b1;
    end
    if (write && !prot[PROT_PRIV] && (addr <= PRIV_TOP)) begin
      deny = 1'b1;
    end
  end

endmodule

// File: rtl/apb_slave_fsm.sv
// APB slave front-end that bridges APB transfers onto a simple register-bank
// request/ready handshake, with protection checking and a bounded wait.
// Ports: APB side PCLK/PRESET/PSEL/PENABLE/PWRITE/PADDR/PWDATA/PPROT in,
//        PRDATA/PREADY/PSLVERR out (all registered);
//        bank side reg_req/reg_wr/reg_addr/reg_wdata out, reg_rdata/reg_ready in.
module apb_slave_fsm
  import apb_slave_fsm_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] SEC_BASE = SEC_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] PRIV_TOP = PRIV_TOP_DEFAULT,
  parameter int                TIMEOUT  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [2:0]        PPROT,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_inc;
  logic              setup;
  logic              deny_now;
  logic              deny_q;
  logic              req_nx;
  logic              resp_err_nx;
  logic [DATA_W-1:0] resp_data_nx;

  assign setup = PSEL && !PENABLE;

  apb_prot_check #(
    .ADDR_W   (ADDR_W),
    .SEC_BASE (SEC_BASE),
    .PRIV_TOP (PRIV_TOP)
  ) u_prot_check (
    .prot  (PPROT),
    .addr  (PADDR),
    .write (PWRITE),
    .deny  (deny_now)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    req_nx       = 1'b0;
    cnt_inc      = 1'b0;
    resp_err_nx  = 1'b0;
    resp_data_nx = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nx = ACCESS;
          // Request is registered so it is high for the ACCESS cycle only.
          req_nx   = !deny_now;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nx = IDLE;
        end else if (deny_q) begin
          state_nx    = RESP;
          resp_err_nx = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_nx = IDLE;
        end else if (reg_ready) begin
          // Checked before the timeout so a completion on the last cycle wins.
          state_nx     = RESP;
          resp_data_nx = reg_wr ? '0 : reg_rdata;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx    = RESP;
          resp_err_nx = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt       <= '0;
      deny_q    <= 1'b0;
      reg_req   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      // Counter runs only while waiting and is zero on entry to WAIT.
      cnt     <= cnt_inc ? cnt + 1'b1 : '0;
      reg_req <= req_nx;
      if (state == IDLE && setup) begin
        reg_wr    <= PWRITE;
        reg_addr  <= PADDR;
        reg_wdata <= PWDATA;
        deny_q    <= deny_now;
      end
      PREADY <= (state_nx == RESP);
      if (state_nx == RESP) begin
        PSLVERR <= resp_err_nx;
        PRDATA  <= resp_data_nx;
      end else begin
        PSLVERR <= 1'b0;
      end
    end
  end

endmodule
